// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch-op encodings, branch-unit FSM states,
// and the hard-wired zero register.
package mips_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_J    = 2'b11
  } br_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } bru_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/comparator.sv
// Team equality comparator used by the ID-stage branch resolution.
module comparator #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: hazard stall FSM, MEM forwarding, taken decision,
// redirect target, IF/ID flush and a wrapping taken-branch counter.
module branch_resolve_unit
  import mips_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            I_BRU_CLK,
  input  logic            I_BRU_RST,
  input  logic            I_BRU_VALID,
  input  logic [1:0]      I_BRU_OP,
  input  logic [4:0]      I_BRU_RS_ADDR,
  input  logic [4:0]      I_BRU_RT_ADDR,
  input  logic [DW-1:0]   I_BRU_RS_DATA,
  input  logic [DW-1:0]   I_BRU_RT_DATA,
  input  logic [DW-1:0]   I_BRU_PC4,
  input  logic [15:0]     I_BRU_IMM,
  input  logic [25:0]     I_BRU_JIDX,
  input  logic            I_BRU_EX_REGWRITE,
  input  logic            I_BRU_EX_MEMREAD,
  input  logic [4:0]      I_BRU_EX_RD,
  input  logic            I_BRU_MEM_REGWRITE,
  input  logic            I_BRU_MEM_MEMREAD,
  input  logic [4:0]      I_BRU_MEM_RD,
  input  logic [DW-1:0]   I_BRU_MEM_ALU,
  output logic            O_BRU_STALL,
  output logic            O_BRU_TAKEN,
  output logic [DW-1:0]   O_BRU_TARGET,
  output logic            O_BRU_FLUSH,
  output logic [CNTW-1:0] O_BRU_TAKEN_CNT
);

  bru_state_e      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [CNTW-1:0] taken_cnt_q;

  br_op_e          op;
  logic            is_br, is_j;
  logic            rs_live, rt_live;
  logic            ex_hit, ex_ld_hit, mem_ld_hit;
  logic [1:0]      need;
  logic [DW-1:0]   rs_fwd, rt_fwd;
  logic            eq;
  logic            stall, resolve, taken;
  logic [DW-1:0]   br_target, j_target;

  assign op    = br_op_e'(I_BRU_OP);
  assign is_br = I_BRU_VALID & ((op == BR_BEQ) | (op == BR_BNE));
  assign is_j  = I_BRU_VALID & (op == BR_J);

  assign rs_live = (I_BRU_RS_ADDR != REG_ZERO);
  assign rt_live = (I_BRU_RT_ADDR != REG_ZERO);

  assign ex_hit     = I_BRU_EX_REGWRITE &
                      ((rs_live & (I_BRU_RS_ADDR == I_BRU_EX_RD)) |
                       (rt_live & (I_BRU_RT_ADDR == I_BRU_EX_RD)));
  assign ex_ld_hit  = ex_hit & I_BRU_EX_MEMREAD;
  assign mem_ld_hit = I_BRU_MEM_REGWRITE & I_BRU_MEM_MEMREAD &
                      ((rs_live & (I_BRU_RS_ADDR == I_BRU_MEM_RD)) |
                       (rt_live & (I_BRU_RT_ADDR == I_BRU_MEM_RD)));

  always_comb begin
    need = 2'd0;
    if (ex_ld_hit)       need = 2'd2;
    else if (ex_hit)     need = 2'd1;
    else if (mem_ld_hit) need = 2'd1;
  end

  // Only ALU results are forwardable from MEM; load data arrives too late.
  assign rs_fwd = (I_BRU_MEM_REGWRITE & ~I_BRU_MEM_MEMREAD & rs_live &
                   (I_BRU_MEM_RD == I_BRU_RS_ADDR)) ? I_BRU_MEM_ALU : I_BRU_RS_DATA;
  assign rt_fwd = (I_BRU_MEM_REGWRITE & ~I_BRU_MEM_MEMREAD & rt_live &
                   (I_BRU_MEM_RD == I_BRU_RT_ADDR)) ? I_BRU_MEM_ALU : I_BRU_RT_DATA;

  comparator #(.W(DW)) u_cmp (
    .a_i  (rs_fwd),
    .b_i  (rt_fwd),
    .eq_o (eq)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    resolve = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_br && (need != 2'd0)) begin
          stall   = 1'b1;
          cnt_d   = need - 2'd1;
          state_d = ST_WAIT;
        end else if (is_br || is_j) begin
          resolve = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!I_BRU_VALID) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 2'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
        end else begin
          resolve = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign taken = resolve & I_BRU_VALID & (((op == BR_BEQ) & eq) |
                                          ((op == BR_BNE) & ~eq) |
                                          (op == BR_J));

  assign br_target = I_BRU_PC4 + {{(DW-18){I_BRU_IMM[15]}}, I_BRU_IMM, 2'b00};
  assign j_target  = {I_BRU_PC4[DW-1:28], I_BRU_JIDX, 2'b00};

  assign O_BRU_STALL     = stall & ~I_BRU_RST;
  assign O_BRU_TAKEN     = taken & ~I_BRU_RST;
  assign O_BRU_FLUSH     = taken & ~I_BRU_RST;
  assign O_BRU_TARGET    = (taken & ~I_BRU_RST) ? ((op == BR_J) ? j_target : br_target) : '0;
  assign O_BRU_TAKEN_CNT = taken_cnt_q;

  always_ff @(posedge I_BRU_CLK or posedge I_BRU_RST) begin
    if (I_BRU_RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (taken) taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected
// per-cycle responses; a negedge monitor pops and compares.
module tb_branch_resolve_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  op;
  logic [4:0]  rs_a, rt_a, ex_rd, mem_rd;
  logic [31:0] rs_d, rt_d, pc4, mem_alu;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic        ex_rw, ex_mr, mem_rw, mem_mr;
  logic        stall_o, taken_o, flush_o;
  logic [31:0] target_o;
  logic [15:0] cnt_o;

  typedef struct {
    logic        stall;
    logic        taken;
    logic [31:0] target;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] exp_cnt;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DW(32), .CNTW(16)) dut (
    .I_BRU_CLK          (clk),
    .I_BRU_RST          (rst),
    .I_BRU_VALID        (valid),
    .I_BRU_OP           (op),
    .I_BRU_RS_ADDR      (rs_a),
    .I_BRU_RT_ADDR      (rt_a),
    .I_BRU_RS_DATA      (rs_d),
    .I_BRU_RT_DATA      (rt_d),
    .I_BRU_PC4          (pc4),
    .I_BRU_IMM          (imm),
    .I_BRU_JIDX         (jidx),
    .I_BRU_EX_REGWRITE  (ex_rw),
    .I_BRU_EX_MEMREAD   (ex_mr),
    .I_BRU_EX_RD        (ex_rd),
    .I_BRU_MEM_REGWRITE (mem_rw),
    .I_BRU_MEM_MEMREAD  (mem_mr),
    .I_BRU_MEM_RD       (mem_rd),
    .I_BRU_MEM_ALU      (mem_alu),
    .O_BRU_STALL        (stall_o),
    .O_BRU_TAKEN        (taken_o),
    .O_BRU_TARGET       (target_o),
    .O_BRU_FLUSH        (flush_o),
    .O_BRU_TAKEN_CNT    (cnt_o)
  );

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks += 5;
      if (stall_o !== e.stall) begin
        failures++;
        $display("FAIL stall t=%0t got=%0b exp=%0b", $time, stall_o, e.stall);
      end
      if (taken_o !== e.taken) begin
        failures++;
        $display("FAIL taken t=%0t got=%0b exp=%0b", $time, taken_o, e.taken);
      end
      if (flush_o !== e.taken) begin
        failures++;
        $display("FAIL flush t=%0t got=%0b exp=%0b", $time, flush_o, e.taken);
      end
      if (target_o !== e.target) begin
        failures++;
        $display("FAIL target t=%0t got=%h exp=%h", $time, target_o, e.target);
      end
      if (cnt_o !== e.cnt) begin
        failures++;
        $display("FAIL taken_cnt t=%0t got=%h exp=%h", $time, cnt_o, e.cnt);
      end
    end
  end

  task automatic clr();
    valid = 1'b0; op = BR_NONE; rs_a = '0; rt_a = '0; rs_d = '0; rt_d = '0;
    pc4 = '0; imm = '0; jidx = '0; ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = '0;
    mem_rw = 1'b0; mem_mr = 1'b0; mem_rd = '0; mem_alu = '0;
  endtask

  task automatic set_br(input logic [1:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [31:0] sd, input logic [31:0] td,
                        input logic [31:0] p, input logic [15:0] im);
    clr();
    valid = 1'b1; op = o; rs_a = s; rt_a = t; rs_d = sd; rt_d = td; pc4 = p; imm = im;
  endtask

  // Inputs are already applied; queue this cycle's expected response and advance.
  task automatic step(input logic es, input logic et, input logic [31:0] etg, input bit chk);
    exp_t e;
    e.stall = es; e.taken = et; e.target = etg; e.cnt = exp_cnt;
    if (chk) sbq.push_back(e);
    if (et) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    clr();
    exp_cnt = '0;
    rst = 1'b1;
    set_br(BR_BEQ, 5'd1, 5'd2, 32'h1234, 32'h1234, 32'h100, 16'h0004);
    #1;
    e.stall = 1'b0; e.taken = 1'b0; e.target = '0; e.cnt = '0;
    sbq.push_back(e);
    @(negedge clk); #1;
    rst = 1'b0;
    clr();
    @(posedge clk); #1;

    // BEQ equal, no hazards
    set_br(BR_BEQ, 5'd1, 5'd2, 32'h1234, 32'h1234, 32'h100, 16'h0004);
    step(1'b0, 1'b1, 32'h110, 1'b1);
    clr(); step(1'b0, 1'b0, 32'h0, 1'b1);

    // BNE behind a load in EX: two stalls then resolve
    set_br(BR_BNE, 5'd2, 5'd3, 32'd5, 32'd6, 32'h200, 16'hFFFC);
    ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd3;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = '0;
    step(1'b0, 1'b1, 32'h1F0, 1'b1);
    set_br(BR_BNE, 5'd2, 5'd3, 32'd5, 32'd5, 32'h200, 16'hFFFC);
    ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd3;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = '0;
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // BEQ behind ALU op in EX: one stall, then MEM forwarding makes it equal
    set_br(BR_BEQ, 5'd4, 5'd5, 32'hAAAA, 32'h77, 32'h300, 16'h0002);
    ex_rw = 1'b1; ex_rd = 5'd4;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    ex_rw = 1'b0; ex_rd = '0;
    mem_rw = 1'b1; mem_rd = 5'd4; mem_alu = 32'h77;
    step(1'b0, 1'b1, 32'h308, 1'b1);

    // Load in MEM: one stall
    set_br(BR_BNE, 5'd6, 5'd7, 32'd1, 32'd2, 32'h400, 16'h0000);
    mem_rw = 1'b1; mem_mr = 1'b1; mem_rd = 5'd7;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    mem_rw = 1'b0; mem_mr = 1'b0; mem_rd = '0;
    step(1'b0, 1'b1, 32'h400, 1'b1);

    // Target wrap cases; r0 never hazards even against a load to r0
    set_br(BR_BEQ, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0002_0000, 16'h8000);
    ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd0;
    step(1'b0, 1'b1, 32'h0, 1'b1);
    set_br(BR_BEQ, 5'd8, 5'd9, 32'h5, 32'h5, 32'hFFFF_FFFC, 16'h0001);
    step(1'b0, 1'b1, 32'h0, 1'b1);

    // Jump ignores hazards
    clr();
    valid = 1'b1; op = BR_J; jidx = 26'h0000040; pc4 = 32'h4000_0008; rs_a = 5'd1;
    ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd1;
    step(1'b0, 1'b1, 32'h4000_0100, 1'b1);

    // OP none and VALID low give nothing despite hazards / equal data
    clr(); valid = 1'b1; rs_a = 5'd1; ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    set_br(BR_BEQ, 5'd1, 5'd2, 32'h9, 32'h9, 32'h600, 16'h0001);
    valid = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Abort from WAIT, then fresh branch resolves from IDLE
    set_br(BR_BEQ, 5'd1, 5'd2, 32'h9, 32'h9, 32'h500, 16'h0001);
    ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd1;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    valid = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    set_br(BR_BEQ, 5'd1, 5'd2, 32'h9, 32'h9, 32'h500, 16'h0001);
    step(1'b0, 1'b1, 32'h504, 1'b1);

    // Counter wrap
    set_br(BR_BEQ, 5'd1, 5'd2, 32'h1, 32'h1, 32'h100, 16'h0000);
    while (exp_cnt != 16'hFFFF) step(1'b0, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    clr(); step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-WAIT
    set_br(BR_BNE, 5'd2, 5'd3, 32'd5, 32'd6, 32'h200, 16'h0001);
    ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd3;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    exp_cnt = '0;
    e.stall = 1'b0; e.taken = 1'b0; e.target = '0; e.cnt = '0;
    sbq.push_back(e);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = '0;
    step(1'b0, 1'b1, 32'h204, 1'b1);
    clr(); step(1'b0, 1'b0, 32'h0, 1'b1);

    @(posedge clk); #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
